// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types for the sequenced magnitude comparator
package cmp_pkg;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} cmp_state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;
endpackage

// File: rtl/comp4.sv
// rtl/comp4.sv - 4-bit unsigned magnitude comparator cell
module comp4
  import cmp_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);
  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);
endmodule

// File: rtl/cmp_seq.sv
// rtl/cmp_seq.sv - nibble-serial magnitude compare, MSB first with early exit
module cmp_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH-1:0]                     a,
  input  logic [WIDTH-1:0]                     b,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 a_gt_b,
  output logic                                 a_lt_b,
  output logic                                 a_eq_b,
  output logic [$clog2(WIDTH/NIB_W+1)-1:0]     steps,
  output logic                                 busy
);
  localparam int N  = WIDTH / NIB_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(N + 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
    $error("cmp_seq: WIDTH must be a positive multiple of 4");
  end

  cmp_state_t       state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic [SW-1:0]    steps_q;
  cmp_res_t         res;
  logic [NIB_W-1:0] nib_a, nib_b;
  logic             c_gt, c_lt, c_eq;

  // Signed compare: flipping the sign bit of the top nibble maps two's complement
  // onto offset binary, so the unsigned cell orders it correctly.
  always_comb begin
    nib_a = a_q[idx*NIB_W +: NIB_W];
    nib_b = b_q[idx*NIB_W +: NIB_W];
    if (SIGNED && idx == IW'(N - 1)) begin
      nib_a[NIB_W-1] = ~nib_a[NIB_W-1];
      nib_b[NIB_W-1] = ~nib_b[NIB_W-1];
    end
  end

  comp4 u_comp4 (
    .a  (nib_a),
    .b  (nib_b),
    .gt (c_gt),
    .lt (c_lt),
    .eq (c_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = SCAN;
      SCAN:    if (!c_eq || idx == '0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      steps_q <= '0;
      res     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          idx     <= IW'(N - 1);
          steps_q <= '0;
        end
        SCAN: begin
          steps_q <= steps_q + SW'(1);
          if (!c_eq)            res <= cmp_res_t'{gt: c_gt, lt: c_lt, eq: 1'b0};
          else if (idx == '0)   res <= cmp_res_t'{gt: 1'b0, lt: 1'b0, eq: 1'b1};
          else                  idx <= idx - IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign a_gt_b    = res.gt;
  assign a_lt_b    = res.lt;
  assign a_eq_b    = res.eq;
  assign steps     = steps_q;
endmodule

// File: tb/tb_cmp_seq.sv
// tb/tb_cmp_seq.sv - directed and randomized checks of cmp_seq (8u, 8s, 16u)
module tb_cmp_seq;
  logic        clk, rst_n;
  logic        iv[3], ir[3], ov[3], ordy[3], gt[3], lt[3], eq[3], bsy[3];
  logic [15:0] av[3], bv[3];
  logic [1:0]  st0, st1;
  logic [2:0]  st2;
  int          errors = 0, checks = 0;

  cmp_seq #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0][7:0]), .b(bv[0][7:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .a_gt_b(gt[0]), .a_lt_b(lt[0]), .a_eq_b(eq[0]),
    .steps(st0), .busy(bsy[0]));
  cmp_seq #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1][7:0]), .b(bv[1][7:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .a_gt_b(gt[1]), .a_lt_b(lt[1]), .a_eq_b(eq[1]),
    .steps(st1), .busy(bsy[1]));
  cmp_seq #(.WIDTH(16), .SIGNED(1'b0)) u_u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(av[2]), .b(bv[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .a_gt_b(gt[2]), .a_lt_b(lt[2]), .a_eq_b(eq[2]),
    .steps(st2), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] st_of(input int w);
    case (w)
      0:       return {1'b0, st0};
      1:       return {1'b0, st1};
      default: return st2;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int w, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, w, obs, exp);
    end
  endtask

  // Reference: flags from a plain integer compare, depth from a nibble scan.
  task automatic golden(input int w, input logic [15:0] x, input logic [15:0] y,
                        output logic [2:0] f, output int k);
    int n;
    logic found;
    logic signed [7:0] sx, sy;
    n = (w == 2) ? 4 : 2;
    k = n;
    found = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!found && x[i*4 +: 4] != y[i*4 +: 4]) begin
        k = n - i;
        found = 1'b1;
      end
    end
    sx = x[7:0];
    sy = y[7:0];
    if (w == 2)      f = {x > y, x < y, x == y};
    else if (w == 1) f = {sx > sy, sx < sy, sx == sy};
    else             f = {x[7:0] > y[7:0], x[7:0] < y[7:0], x[7:0] == y[7:0]};
  endtask

  // Full transaction: accept, count latency, check result, hold, release.
  task automatic run_op(input int w, input logic [15:0] x, input logic [15:0] y,
                        input logic [2:0] f, input int k, input int hold);
    int lat;
    av[w] = x; bv[w] = y; iv[w] = 1'b1;
    check("in_ready_idle", w, ir[w], 1'b1);
    step();
    av[w] = ~x;
    lat = 0;
    while (!ov[w] && lat < 20) begin
      step();
      lat++;
    end
    check("latency", w, lat, k);
    check("flags", w, {gt[w], lt[w], eq[w]}, f);
    check("steps", w, st_of(w), k);
    check("one_hot", w, gt[w] + lt[w] + eq[w], 1);
    check("busy", w, bsy[w], 1'b1);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", w, ov[w], 1'b1);
      check("hold_flags", w, {gt[w], lt[w], eq[w], st_of(w)}, {f, 3'(k)});
    end
    iv[w] = 1'b0;
    ordy[w] = 1'b1;
    step();
    ordy[w] = 1'b0;
    check("post_valid", w, ov[w], 1'b0);
    check("post_ready", w, ir[w], 1'b1);
  endtask

  logic [15:0] px[3], py[3];
  logic [2:0]  pf[3];
  int          pk[3], nres, nacc, cyc, seen;
  logic        acc, hnd;
  logic [2:0]  gf;
  int          gk;
  logic [15:0] rx, ry;

  initial begin
    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) begin
      iv[w] = 1'b0; ordy[w] = 1'b0; av[w] = '0; bv[w] = '0;
    end
    step();
    for (int w = 0; w < 3; w++) begin
      check("rst_state", w, {ir[w], ov[w], bsy[w], gt[w], lt[w], eq[w], st_of(w)}, 9'b100_000_000);
    end
    step();
    rst_n = 1'b1;
    step();

    run_op(0, 16'h005A, 16'h003A, 3'b100, 1, 0);
    run_op(0, 16'h0037, 16'h003C, 3'b010, 2, 5);
    run_op(0, 16'h00C4, 16'h00C4, 3'b001, 2, 0);
    run_op(1, 16'h0080, 16'h007F, 3'b010, 1, 0);
    run_op(0, 16'h0080, 16'h007F, 3'b100, 1, 0);
    run_op(1, 16'h0038, 16'h003F, 3'b010, 2, 0);
    run_op(1, 16'h00F0, 16'h000F, 3'b010, 1, 0);
    run_op(1, 16'h00FF, 16'h00F0, 3'b100, 2, 0);

    // Reset two edges into a four-nibble compare.
    av[2] = 16'h1234; bv[2] = 16'h1235; iv[2] = 1'b1;
    step();
    iv[2] = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 2, ir[2], 1'b1);
    check("midrst_valid", 2, ov[2], 1'b0);
    check("midrst_busy", 2, bsy[2], 1'b0);
    step();
    check("midrst_ready2", 2, ir[2], 1'b1);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ov[2]) seen++;
    end
    check("midrst_no_result", 2, seen, 0);
    run_op(2, 16'h1234, 16'h1235, 3'b010, 4, 0);
    run_op(2, 16'hA000, 16'h9FFF, 3'b100, 1, 0);
    run_op(2, 16'h1234, 16'h1234, 3'b001, 4, 0);
    run_op(2, 16'h5678, 16'h5608, 3'b100, 3, 0);

    // Back-to-back: in_valid and out_ready held high across three operations.
    px[0] = 16'h5A; py[0] = 16'h3A; pf[0] = 3'b100; pk[0] = 1;
    px[1] = 16'h37; py[1] = 16'h3C; pf[1] = 3'b010; pk[1] = 2;
    px[2] = 16'hC4; py[2] = 16'hC4; pf[2] = 3'b001; pk[2] = 2;
    nres = 0; nacc = 0; cyc = 0;
    av[0] = px[0]; bv[0] = py[0]; iv[0] = 1'b1; ordy[0] = 1'b1;
    while (nres < 3 && cyc < 60) begin
      acc = iv[0] && ir[0];
      hnd = ov[0] && ordy[0];
      if (hnd) begin
        check("b2b_flags", 0, {gt[0], lt[0], eq[0]}, pf[nres]);
        check("b2b_steps", 0, st_of(0), pk[nres]);
      end
      step();
      cyc++;
      if (hnd) nres++;
      if (acc) begin
        nacc++;
        if (nacc < 3) begin av[0] = px[nacc]; bv[0] = py[nacc]; end
        else iv[0] = 1'b0;
      end
    end
    ordy[0] = 1'b0;
    check("b2b_results", 0, nres, 3);
    check("b2b_accepts", 0, nacc, 3);
    check("b2b_cycles", 0, cyc, 11);
    step();

    for (int i = 0; i < 1000; i++) begin
      for (int w = 0; w < 3; w++) begin
        rx = 16'($urandom);
        ry = 16'($urandom);
        if ($urandom_range(3) == 0) ry[15:4] = rx[15:4];
        if ($urandom_range(7) == 0) ry = rx;
        if (w < 2) begin rx[15:8] = '0; ry[15:8] = '0; end
        golden(w, rx, ry, gf, gk);
        run_op(w, rx, ry, gf, gk, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
